// File: rtl/axil_pkg.sv
// axil_pkg: response codes, FSM state types and address-to-word helper for the register bank
package axil_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [2:0] {W_IDLE, W_WAIT_W, W_WAIT_AW, W_PUSH, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;
  function automatic logic [31:0] word_index(input logic [31:0] addr);
    return addr >> 2;
  endfunction
endpackage

// File: rtl/axil_stream_regbank_if.sv
// axil_stream_regbank_if: AXI4-Lite bus bundle with master/slave views
interface axil_stream_regbank_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] awaddr;
  logic awvalid, awready;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic wvalid, wready;
  logic [1:0] bresp;
  logic bvalid, bready;
  logic [ADDR_W-1:0] araddr;
  logic arvalid, arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0] rresp;
  logic rvalid, rready;
  modport master(
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave(
    input awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_lite_wr_ctrl.sv
// axil_lite_wr_ctrl: AXI4-Lite write FSM with byte-strobe shadow merge and push timeout
module axil_lite_wr_ctrl
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_WR = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset,
  axil_stream_regbank_if.slave s,
  output logic [N_WR*DATA_W-1:0] wr_tdata,
  output logic [N_WR-1:0] wr_tvalid,
  input  logic [N_WR-1:0] wr_tready
);
  localparam int unsigned CW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
  w_state_t state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data, mask;
  logic [DATA_W/8-1:0] strb;
  logic [CW-1:0] cnt;
  logic [1:0] resp;
  logic [31:0] widx;
  logic [N_WR-1:0] sel;
  logic [N_WR-1:0][DATA_W-1:0] shadow, shadow_n;
  logic aw_hs, w_hs, mapped, pushing, entry, tready_hit, timed_out;
  assign widx = word_index(32'(addr));
  for (genvar b = 0; b < DATA_W / 8; b++) begin : g_mask
    assign mask[b*8 +: 8] = {8{strb[b]}};
  end
  // shadow merge happens once, in the first W_PUSH cycle
  for (genvar g = 0; g < N_WR; g++) begin : g_sel
    assign sel[g] = widx == 32'(g + 1);
    assign shadow_n[g] = entry && sel[g] ? (shadow[g] & ~mask) | (data & mask) : shadow[g];
  end
  assign mapped = |sel;
  assign pushing = |wr_tvalid;
  assign entry = state == W_PUSH && !pushing;
  assign tready_hit = |(wr_tvalid & wr_tready);
  assign timed_out = TIMEOUT_CYC != 0 && cnt == CW'(TIMEOUT_CYC - 1);
  assign aw_hs = s.awvalid && s.awready;
  assign w_hs = s.wvalid && s.wready;
  assign s.awready = state == W_IDLE || state == W_WAIT_AW;
  assign s.wready = state == W_IDLE || state == W_WAIT_W;
  assign s.bvalid = state == W_RESP;
  assign s.bresp = resp;
  assign wr_tdata = shadow;
  always_comb begin
    state_n = state;
    unique case (state)
      W_IDLE: state_n = aw_hs && w_hs ? W_PUSH : aw_hs ? W_WAIT_W : w_hs ? W_WAIT_AW : W_IDLE;
      W_WAIT_W: state_n = w_hs ? W_PUSH : W_WAIT_W;
      W_WAIT_AW: state_n = aw_hs ? W_PUSH : W_WAIT_AW;
      W_PUSH: state_n = !pushing ? (mapped ? W_PUSH : W_RESP) : tready_hit || timed_out ? W_RESP : W_PUSH;
      W_RESP: state_n = s.bready ? W_IDLE : W_RESP;
      default: state_n = W_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= W_IDLE;
      addr <= '0;
      data <= '0;
      strb <= '0;
      cnt <= '0;
      resp <= RESP_OKAY;
      wr_tvalid <= '0;
      shadow <= '0;
    end else begin
      state <= state_n;
      shadow <= shadow_n;
      if (aw_hs) addr <= s.awaddr;
      if (w_hs) begin
        data <= s.wdata;
        strb <= s.wstrb;
      end
      if (entry) begin
        cnt <= '0;
        wr_tvalid <= sel;
        resp <= mapped ? RESP_OKAY : RESP_SLVERR;
      end else if (pushing) begin
        if (tready_hit || timed_out) begin
          wr_tvalid <= '0;
          resp <= tready_hit ? RESP_OKAY : RESP_SLVERR;
        end else cnt <= cnt + 1'b1;
      end
    end
endmodule

// File: rtl/axil_stream_regbank.sv
// axil_stream_regbank: AXI4-Lite register window onto write/read stream channels
module axil_stream_regbank
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_WR = 4,
  parameter int unsigned N_RD = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset,
  axil_stream_regbank_if.slave s,
  output logic [N_WR*DATA_W-1:0] wr_tdata,
  output logic [N_WR-1:0] wr_tvalid,
  input  logic [N_WR-1:0] wr_tready,
  input  logic [N_RD*DATA_W-1:0] rd_tdata,
  input  logic [N_RD-1:0] rd_tvalid,
  output logic [N_RD-1:0] rd_tready
);
  r_state_t state, state_n;
  logic [ADDR_W-1:0] raddr;
  logic [31:0] ridx;
  logic [N_RD-1:0] rsel, pop;
  logic [N_RD:0][DATA_W-1:0] acc;
  logic [DATA_W-1:0] rdata;
  logic [1:0] rresp;
  axil_lite_wr_ctrl #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .N_WR(N_WR),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wr (
    .clk(clk),
    .reset(reset),
    .s(s),
    .wr_tdata(wr_tdata),
    .wr_tvalid(wr_tvalid),
    .wr_tready(wr_tready)
  );
  assign ridx = word_index(32'(raddr));
  assign acc[0] = '0;
  // a channel without valid data reads as zero and is not popped
  for (genvar g = 0; g < N_RD; g++) begin : g_rd
    assign rsel[g] = ridx == 32'(g + 1);
    assign acc[g+1] = acc[g] | (rsel[g] && rd_tvalid[g] ? rd_tdata[g*DATA_W +: DATA_W] : '0);
  end
  assign s.arready = state == R_IDLE;
  assign s.rvalid = state == R_DATA;
  assign s.rdata = rdata;
  assign s.rresp = rresp;
  assign rd_tready = s.rvalid && s.rready ? pop : '0;
  always_comb begin
    state_n = state == R_IDLE ? (s.arvalid ? R_FETCH : R_IDLE) : state == R_FETCH ? R_DATA : s.rready ? R_IDLE : R_DATA;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= R_IDLE;
      raddr <= '0;
      rdata <= '0;
      rresp <= RESP_OKAY;
      pop <= '0;
    end else begin
      state <= state_n;
      if (s.arvalid && s.arready) raddr <= s.araddr;
      if (state == R_FETCH) begin
        rdata <= ridx == 0 ? DATA_W'({rd_tvalid, wr_tready}) : acc[N_RD];
        rresp <= ridx == 0 || |rsel ? RESP_OKAY : RESP_SLVERR;
        pop <= rsel & rd_tvalid;
      end
    end
endmodule

// File: tb/tb_axil_stream_regbank.sv
// tb_axil_stream_regbank: directed AXI-Lite transactions checked against a transaction-level model
module tb_axil_stream_regbank;
  import axil_pkg::*;
  localparam int TO = 255;
  logic clk = 0, reset = 1;
  logic [127:0] wr_tdata, rd_tdata;
  logic [3:0] wr_tvalid, wr_tready, rd_tvalid, rd_tready;
  axil_stream_regbank_if #(.ADDR_W(8), .DATA_W(32)) s ();
  axil_stream_regbank #(
    .ADDR_W(8), .DATA_W(32), .N_WR(4), .N_RD(4), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .reset(reset), .s(s),
    .wr_tdata(wr_tdata), .wr_tvalid(wr_tvalid), .wr_tready(wr_tready),
    .rd_tdata(rd_tdata), .rd_tvalid(rd_tvalid), .rd_tready(rd_tready)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0, tv_cycles = 0, pops = 0;
  logic chk_en = 0;
  logic [127:0] exp_sh = '0;
  logic [3:0] exp_tvalid = '0, exp_rdtready = '0;
  logic exp_bvalid = 0, exp_rvalid = 0;
  logic [1:0] exp_bresp = '0, exp_rresp = '0;
  logic [31:0] exp_rdata = '0;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // per-cycle comparison of DUT outputs against the model's expectations
  always @(negedge clk) begin
    if (|wr_tvalid) tv_cycles++;
    if (rd_tready[1]) pops++;
    if (chk_en) begin
      chk("wr_tvalid", 128'(wr_tvalid), 128'(exp_tvalid));
      chk("wr_tdata", wr_tdata, exp_sh);
      chk("bvalid", 128'(s.bvalid), 128'(exp_bvalid));
      if (exp_bvalid) chk("bresp", 128'(s.bresp), 128'(exp_bresp));
      chk("rvalid", 128'(s.rvalid), 128'(exp_rvalid));
      if (exp_rvalid) begin
        chk("rdata", 128'(s.rdata), 128'(exp_rdata));
        chk("rresp", 128'(s.rresp), 128'(exp_rresp));
      end
      chk("rd_tready", 128'(rd_tready), 128'(exp_rdtready));
    end
  end
  // lead > 0: W presented lead cycles before AW; lead < 0: AW first; rdy drives every wr_tready
  task automatic write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] st,
                       input int lead, input logic rdy, output logic [1:0] bresp);
    int k, lag;
    logic [127:0] m;
    k = int'(a >> 2);
    lag = lead < 0 ? -lead : lead;
    wr_tready = {4{rdy}};
    s.awaddr = a;
    s.wdata = d;
    s.wstrb = st;
    if (lead >= 0) s.wvalid = 1;
    if (lead <= 0) s.awvalid = 1;
    step();
    if (lead != 0) begin
      s.awvalid = 0;
      s.wvalid = 0;
      chk("wait_ready", 128'({s.awready, s.wready}), lead > 0 ? 128'(2'b10) : 128'(2'b01));
      repeat (lag - 1) step();
      if (lead > 0) s.awvalid = 1;
      else s.wvalid = 1;
      step();
    end
    s.awvalid = 0;
    s.wvalid = 0;
    exp_bresp = RESP_SLVERR;
    if (k >= 1 && k <= 4) begin
      step();
      m = '0;
      for (int j = 0; j < 4; j++) if (((st >> j) & 4'd1) != 0) m |= 128'hFF << (32 * (k - 1) + 8 * j);
      exp_sh = (exp_sh & ~m) | ((128'(d) << (32 * (k - 1))) & m);
      exp_tvalid = 4'(1 << (k - 1));
      for (int n = 1; !rdy && n < TO; n++) step();
      exp_bresp = rdy ? RESP_OKAY : RESP_SLVERR;
    end
    step();
    exp_tvalid = '0;
    exp_bvalid = 1;
    bresp = s.bresp;
    s.bready = 1;
    step();
    s.bready = 0;
    exp_bvalid = 0;
    chk("aw_back_idle", 128'(s.awready), 128'(1));
  endtask
  task automatic read(input logic [7:0] a, input int delay, output logic [31:0] rd, output logic [1:0] rr);
    int k;
    logic hit;
    k = int'(a >> 2);
    s.araddr = a;
    s.arvalid = 1;
    step();
    s.arvalid = 0;
    hit = k >= 1 && k <= 4 && ((rd_tvalid >> (k - 1)) & 4'd1) != 0;
    exp_rdata = k == 0 ? 32'({rd_tvalid, wr_tready}) : hit ? 32'(rd_tdata >> (32 * (k - 1))) : 32'd0;
    exp_rresp = k <= 4 ? RESP_OKAY : RESP_SLVERR;
    step();
    exp_rvalid = 1;
    rd = s.rdata;
    rr = s.rresp;
    repeat (delay) step();
    s.rready = 1;
    exp_rdtready = hit ? 4'(1 << (k - 1)) : 4'd0;
    step();
    s.rready = 0;
    exp_rvalid = 0;
    exp_rdtready = '0;
    chk("ar_back_idle", 128'(s.arready), 128'(1));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    logic [1:0] br, rr;
    logic [31:0] rd;
    int t0, p0;
    s.awaddr = '0; s.awvalid = 0; s.wdata = '0; s.wstrb = '0; s.wvalid = 0; s.bready = 0;
    s.araddr = '0; s.arvalid = 0; s.rready = 0;
    wr_tready = '0; rd_tdata = '0; rd_tvalid = '0;
    repeat (3) step();
    chk("rst_awready", 128'(s.awready), 128'(1));
    chk("rst_wready", 128'(s.wready), 128'(1));
    chk("rst_arready", 128'(s.arready), 128'(1));
    chk("rst_bvalid", 128'(s.bvalid), 128'(0));
    chk("rst_rvalid", 128'(s.rvalid), 128'(0));
    chk("rst_tvalid", 128'(wr_tvalid), 128'(0));
    chk("rst_rdtready", 128'(rd_tready), 128'(0));
    chk("rst_tdata", wr_tdata, 128'(0));
    reset = 0;
    chk_en = 1;
    t0 = tv_cycles;
    write(8'h04, 32'hA5A5_0001, 4'hF, 0, 1, br);
    chk("t1_bresp", 128'(br), 128'(2'b00));
    chk("t1_tdata0", 128'(wr_tdata[31:0]), 128'(32'hA5A5_0001));
    chk("t1_tvalid_cycles", 128'(tv_cycles - t0), 128'(1));
    write(8'h08, 32'h0000_BB00, 4'b0010, 2, 1, br);
    chk("t2_bresp", 128'(br), 128'(2'b00));
    chk("t2_tdata1", 128'(wr_tdata[63:32]), 128'(32'h0000_BB00));
    write(8'h08, 32'h1122_3344, 4'b1101, -3, 1, br);
    chk("merge_tdata1", 128'(wr_tdata[63:32]), 128'(32'h1122_BB44));
    t0 = tv_cycles;
    write(8'h0C, 32'hCAFE_0003, 4'hF, 0, 0, br);
    chk("to_bresp", 128'(br), 128'(2'b10));
    chk("to_tvalid_cycles", 128'(tv_cycles - t0), 128'(255));
    chk("to_tdata2", 128'(wr_tdata[95:64]), 128'(32'hCAFE_0003));
    t0 = tv_cycles;
    write(8'h00, 32'hFFFF_FFFF, 4'hF, 0, 1, br);
    chk("w0_bresp", 128'(br), 128'(2'b10));
    write(8'h14, 32'hFFFF_FFFF, 4'hF, 1, 1, br);
    chk("w5_bresp", 128'(br), 128'(2'b10));
    chk("unmapped_no_push", 128'(tv_cycles - t0), 128'(0));
    write(8'h13, 32'h4444_0004, 4'hF, 0, 1, br);
    chk("lowbits_tdata3", 128'(wr_tdata[127:96]), 128'(32'h4444_0004));
    rd_tvalid = 4'b0010;
    rd_tdata[63:32] = 32'hDEAD_BEEF;
    p0 = pops;
    read(8'h08, 5, rd, rr);
    chk("r2_rdata", 128'(rd), 128'(32'hDEAD_BEEF));
    chk("r2_rresp", 128'(rr), 128'(2'b00));
    chk("r2_pops", 128'(pops - p0), 128'(1));
    rd_tvalid = 4'b0000;
    p0 = pops;
    read(8'h08, 0, rd, rr);
    chk("r2_empty_rdata", 128'(rd), 128'(0));
    chk("r2_empty_rresp", 128'(rr), 128'(2'b00));
    chk("r2_empty_pops", 128'(pops - p0), 128'(0));
    rd_tvalid = 4'b0101;
    rd_tdata[31:0] = 32'h0123_4567;
    wr_tready = 4'hF;
    read(8'h00, 1, rd, rr);
    chk("r0_status", 128'(rd), 128'(32'h0000_005F));
    read(8'h04, 2, rd, rr);
    chk("r1_rdata", 128'(rd), 128'(32'h0123_4567));
    read(8'h24, 0, rd, rr);
    chk("r9_rdata", 128'(rd), 128'(0));
    chk("r9_rresp", 128'(rr), 128'(2'b10));
    wr_tready = '0;
    s.awaddr = 8'h0C; s.wdata = 32'h7777_0000; s.wstrb = 4'hF; s.awvalid = 1; s.wvalid = 1;
    step();
    s.awvalid = 0;
    s.wvalid = 0;
    step();
    exp_sh[95:64] = 32'h7777_0000;
    exp_tvalid = 4'b0100;
    step();
    chk("rst_mid_tvalid", 128'(wr_tvalid), 128'(4'b0100));
    reset = 1;
    step();
    exp_tvalid = '0;
    exp_sh = '0;
    chk("rst_mid_awready", 128'(s.awready), 128'(1));
    chk("rst_mid_bvalid", 128'(s.bvalid), 128'(0));
    chk("rst_mid_tvalid_off", 128'(wr_tvalid), 128'(0));
    reset = 0;
    repeat (4) step();
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
